// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and default sizing for the threshold-scan sequencer
package scan_pkg;

   localparam int DAC_W_DEF       = 12;
   localparam int CNT_W_DEF       = 32;
   localparam int SETTLE_W_DEF    = 16;
   localparam int TIMEOUT_CYC_DEF = 50_000_000;

   // count reported for a step whose counter gate never completed
   localparam logic [CNT_W_DEF-1:0] TIMEOUT_COUNT = '1;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      WAIT_DAC,
      SETTLE,
      GATE,
      WAIT_CNT,
      EMIT,
      NEXT,
      DONE
   } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - loadable down-counter with zero flag, used for settle and timeout delays
module scan_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // load has priority; decrement stops at zero so the flag stays asserted
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - DAC threshold-scan controller; optional SCAN_TIMEOUT_EN adds wait timeouts
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int DAC_W    = DAC_W_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int SETTLE_W = SETTLE_W_DEF
`ifdef SCAN_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
   input  logic                clock50Mhz,
   input  logic                reset,
   input  logic [DAC_W-1:0]    cfg_start,
   input  logic [DAC_W-1:0]    cfg_stop,
   input  logic [DAC_W-1:0]    cfg_step,
   input  logic [SETTLE_W-1:0] cfg_settle,
   input  logic                start,
   input  logic                abort,
   output logic [DAC_W-1:0]    dac_code,
   output logic                dac_load,
   input  logic                dac_busy,
   output logic                cnt_start,
   input  logic                cnt_done,
   input  logic [CNT_W-1:0]    cnt_value,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [DAC_W-1:0]    res_code,
   output logic [CNT_W-1:0]    res_count,
   output logic                busy,
   output logic                done
`ifdef SCAN_TIMEOUT_EN
   , output logic              timeout_err
`endif
);

   scan_state_t         state, state_nx;
   logic [DAC_W-1:0]    code, start_r, stop_r, step_r;
   logic [SETTLE_W-1:0] settle_r;
   logic                dac_armed;
   logic                settle_load, settle_dec, settle_zero;
   logic                dac_timeout, cnt_timeout;
   logic [DAC_W:0]      next_sum;
   logic                last_step;

   // one extra bit on the sum so a step past the top code ends the scan instead of wrapping
   assign next_sum  = {1'b0, code} + {1'b0, step_r};
   assign last_step = (code == stop_r) || (step_r == '0) || (start_r > stop_r)
                    || (next_sum > {1'b0, stop_r});

   scan_timer #(.W(SETTLE_W)) u_settle (
      .clk      (clock50Mhz),
      .rst      (reset),
      .load     (settle_load),
      .load_val (settle_r - 1'b1),
      .dec      (settle_dec),
      .zero     (settle_zero)
   );

`ifdef SCAN_TIMEOUT_EN
   logic to_load, to_dec, to_zero;

   assign to_load     = (state_nx != state) && (state_nx == WAIT_DAC || state_nx == WAIT_CNT);
   assign to_dec      = (state == WAIT_DAC) || (state == WAIT_CNT);
   assign dac_timeout = (state == WAIT_DAC) && to_zero;
   assign cnt_timeout = (state == WAIT_CNT) && to_zero && !cnt_done;

   scan_timer #(.W(32)) u_timeout (
      .clk      (clock50Mhz),
      .rst      (reset),
      .load     (to_load),
      .load_val (32'(TIMEOUT_CYC - 1)),
      .dec      (to_dec),
      .zero     (to_zero)
   );

   // error flag is sticky across the scan and cleared when the next scan is accepted
   always_ff @(posedge clock50Mhz or posedge reset) begin
      if (reset)
         timeout_err <= 1'b0;
      else if (state == IDLE && start)
         timeout_err <= 1'b0;
      else if (dac_timeout || cnt_timeout)
         timeout_err <= 1'b1;
   end
`else
   assign dac_timeout = 1'b0;
   assign cnt_timeout = 1'b0;
`endif

   // next-state selection; abort overrides every active state
   always_comb begin
      state_nx    = state;
      settle_load = 1'b0;
      settle_dec  = 1'b0;
      case (state)
         IDLE:     if (start) state_nx = LOAD;
         LOAD:     state_nx = WAIT_DAC;
         WAIT_DAC: begin
            if (dac_timeout)
               state_nx = DONE;
            else if (dac_armed && !dac_busy) begin
               if (settle_r == '0)
                  state_nx = GATE;
               else begin
                  settle_load = 1'b1;
                  state_nx    = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (settle_zero)
               state_nx = GATE;
            else
               settle_dec = 1'b1;
         end
         GATE:     state_nx = WAIT_CNT;
         WAIT_CNT: if (cnt_done || cnt_timeout) state_nx = EMIT;
         EMIT:     if (res_ready) state_nx = NEXT;
         NEXT:     state_nx = last_step ? DONE : LOAD;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
      if (abort && state != IDLE && state != DONE)
         state_nx = DONE;
   end

   // state register, config capture, strobes and the result record
   always_ff @(posedge clock50Mhz or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         code      <= '0;
         start_r   <= '0;
         stop_r    <= '0;
         step_r    <= '0;
         settle_r  <= '0;
         dac_armed <= 1'b0;
         dac_code  <= '0;
         dac_load  <= 1'b0;
         cnt_start <= 1'b0;
         res_valid <= 1'b0;
         res_code  <= '0;
         res_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         dac_load  <= (state == LOAD) && (state_nx == WAIT_DAC);
         cnt_start <= (state == GATE) && (state_nx == WAIT_CNT);
         done      <= (state_nx == DONE);
         busy      <= (state_nx != IDLE) && (state_nx != DONE);
         // the spidac needs a cycle after the load strobe before its busy is meaningful
         dac_armed <= (state == WAIT_DAC);
         if (state == IDLE && start) begin
            code     <= cfg_start;
            start_r  <= cfg_start;
            stop_r   <= cfg_stop;
            step_r   <= cfg_step;
            settle_r <= cfg_settle;
         end
         if (state == LOAD && state_nx == WAIT_DAC)
            dac_code <= code;
         if (state == NEXT && state_nx == LOAD)
            code <= next_sum[DAC_W-1:0];
         if (state == WAIT_CNT && state_nx == EMIT) begin
            res_valid <= 1'b1;
            res_code  <= code;
            res_count <= cnt_done ? cnt_value : '1;
         end else if (state_nx != EMIT) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - randomized scoreboard bench for scan_sequencer
module tb_scan_sequencer;
   import scan_pkg::*;

   localparam int DAC_W    = 12;
   localparam int CNT_W    = 32;
   localparam int SETTLE_W = 16;

   logic                clock50Mhz = 1'b0;
   logic                reset;
   logic [DAC_W-1:0]    cfg_start, cfg_stop, cfg_step;
   logic [SETTLE_W-1:0] cfg_settle;
   logic                start, abort;
   logic [DAC_W-1:0]    dac_code, res_code;
   logic                dac_load, dac_busy, cnt_start, cnt_done;
   logic [CNT_W-1:0]    cnt_value, res_count;
   logic                res_valid, res_ready, busy, done;
`ifdef SCAN_TIMEOUT_EN
   logic                timeout_err;
`endif

   int checks = 0;
   int errors = 0;

   int               ref_codes[$];
   logic [DAC_W-1:0] exp_code[$];
   logic [CNT_W-1:0] exp_count[$];
   int               n_load = 0;
   int               n_gate = 0;
   int               cnt_idx = 0;
   int               ready_mode = 0;
   int               cnt_delay_max = 4;
   bit               cnt_enable = 1'b1;
   int               salt = 0;

`ifdef SCAN_TIMEOUT_EN
   scan_sequencer #(.TIMEOUT_CYC(100)) dut (
      .clock50Mhz (clock50Mhz),
      .reset      (reset),
      .cfg_start  (cfg_start),
      .cfg_stop   (cfg_stop),
      .cfg_step   (cfg_step),
      .cfg_settle (cfg_settle),
      .start      (start),
      .abort      (abort),
      .dac_code   (dac_code),
      .dac_load   (dac_load),
      .dac_busy   (dac_busy),
      .cnt_start  (cnt_start),
      .cnt_done   (cnt_done),
      .cnt_value  (cnt_value),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_code   (res_code),
      .res_count  (res_count),
      .busy       (busy),
      .timeout_err(timeout_err),
      .done       (done)
   );
`else
   scan_sequencer dut (
      .clock50Mhz (clock50Mhz),
      .reset      (reset),
      .cfg_start  (cfg_start),
      .cfg_stop   (cfg_stop),
      .cfg_step   (cfg_step),
      .cfg_settle (cfg_settle),
      .start      (start),
      .abort      (abort),
      .dac_code   (dac_code),
      .dac_load   (dac_load),
      .dac_busy   (dac_busy),
      .cnt_start  (cnt_start),
      .cnt_done   (cnt_done),
      .cnt_value  (cnt_value),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_code   (res_code),
      .res_count  (res_count),
      .busy       (busy),
      .done       (done)
   );
`endif

   always #5 clock50Mhz = ~clock50Mhz;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // reference scan: list of codes visited, from plain integer arithmetic
   task automatic build_ref(input int s, input int e, input int st);
      int c;
      ref_codes.delete();
      c = s;
      forever begin
         ref_codes.push_back(c);
         if (st == 0 || s > e || c + st > e) break;
         c = c + st;
      end
   endtask

   function automatic logic [CNT_W-1:0] cnt_of(input int i);
      if (!cnt_enable) return TIMEOUT_COUNT;
      return CNT_W'(ref_codes[i] * 3 + salt);
   endfunction

   // spidac model: busy for a few cycles starting the cycle after the load strobe
   initial begin
      int n;
      dac_busy = 1'b0;
      forever begin
         @(negedge clock50Mhz);
         if (dac_load && !reset) begin
            n = $urandom_range(1, 4);
            @(negedge clock50Mhz);
            dac_busy = 1'b1;
            repeat (n) @(negedge clock50Mhz);
            dac_busy = 1'b0;
         end
      end
   end

   // counter model: returns the reference count for the n-th gate of the scan
   initial begin
      int d, g;
      cnt_done  = 1'b0;
      cnt_value = '0;
      forever begin
         @(negedge clock50Mhz);
         if (cnt_start && !reset && cnt_enable) begin
            g = cnt_idx;
            cnt_idx++;
            d = $urandom_range(1, cnt_delay_max);
            repeat (d) @(negedge clock50Mhz);
            cnt_value = (g < ref_codes.size()) ? cnt_of(g) : 32'hDEAD_BEEF;
            cnt_done  = 1'b1;
            @(negedge clock50Mhz);
            cnt_done  = 1'b0;
            cnt_value = $urandom;
         end
      end
   end

   // consumer back-pressure
   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clock50Mhz);
         #1;
         case (ready_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
         endcase
      end
   end

   // monitor: scoreboard pops, record hold stability, strobe counting
   initial begin
      logic             pv, prdy;
      logic [DAC_W-1:0] pc;
      logic [CNT_W-1:0] pn;
      pv = 1'b0; prdy = 1'b0; pc = '0; pn = '0;
      forever begin
         @(negedge clock50Mhz);
         if (reset) begin
            pv = 1'b0;
            continue;
         end
         if (pv && !prdy) begin
            check("hold_valid", res_valid, 1);
            check("hold_code", res_code, pc);
            check("hold_count", res_count, pn);
         end
         if (dac_load) begin
            check("load_while_valid", res_valid, 0);
            if (n_load < ref_codes.size())
               check("dac_code", dac_code, ref_codes[n_load]);
            else
               check("extra_dac_load", n_load + 1, ref_codes.size());
            n_load++;
         end
         if (cnt_start) n_gate++;
         if (res_valid && res_ready) begin
            if (exp_code.size() == 0)
               check("unexpected_record", res_code, '1);
            else begin
               check("res_code", res_code, exp_code.pop_front());
               check("res_count", res_count, exp_count.pop_front());
            end
         end
         pv = res_valid; prdy = res_ready; pc = res_code; pn = res_count;
      end
   end

   task automatic start_scan(input int s, input int e, input int st, input int se,
                             input int max_recs, input bit with_abort);
      build_ref(s, e, st);
      n_load  = 0;
      n_gate  = 0;
      cnt_idx = 0;
      for (int i = 0; i < ref_codes.size() && i < max_recs; i++) begin
         exp_code.push_back(DAC_W'(ref_codes[i]));
         exp_count.push_back(cnt_of(i));
      end
      @(negedge clock50Mhz);
      cfg_start  = DAC_W'(s);
      cfg_stop   = DAC_W'(e);
      cfg_step   = DAC_W'(st);
      cfg_settle = SETTLE_W'(se);
      start      = 1'b1;
      abort      = with_abort;
      @(negedge clock50Mhz);
      start      = 1'b0;
      abort      = 1'b0;
      cfg_start  = DAC_W'($urandom);
      cfg_stop   = DAC_W'($urandom);
      cfg_step   = DAC_W'($urandom);
      cfg_settle = SETTLE_W'($urandom);
      check("busy_after_start", busy, 1);
      check("no_load_cycle1", dac_load, 0);
      @(negedge clock50Mhz);
      check("first_load_latency", dac_load, 1);
   endtask

   task automatic wait_done(input int bound);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clock50Mhz);
         if (done) begin
            seen = 1'b1;
            break;
         end
         start = (i == 5);
      end
      start = 1'b0;
      check("done_seen", seen, 1);
      check("busy_at_done", busy, 0);
      check("records_drained", exp_code.size(), 0);
      @(negedge clock50Mhz);
      check("done_one_cycle", done, 0);
      check("dac_load_count", n_load, ref_codes.size());
      check("cnt_start_count", n_gate, ref_codes.size());
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dac_code"}, dac_code, 0);
      check({tag, "_dac_load"}, dac_load, 0);
      check({tag, "_cnt_start"}, cnt_start, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_code"}, res_code, 0);
      check({tag, "_res_count"}, res_count, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, e, st;
      bit ok;
      reset = 1'b1;
      start = 1'b0; abort = 1'b0;
      cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_settle = '0;
      repeat (3) @(negedge clock50Mhz);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clock50Mhz);
      check_all_zero("post_reset");

      // abort while idle does nothing
      abort = 1'b1;
      @(negedge clock50Mhz);
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_done", done, 0);

      // directed scans
      salt = 0; ready_mode = 0;
      start_scan(10, 14, 2, 4, 99, 1'b0);
      wait_done(3000);
      start_scan(4090, 4095, 4, 2, 99, 1'b0);
      wait_done(3000);
      start_scan(100, 200, 0, 1, 99, 1'b0);
      wait_done(3000);
      start_scan(200, 100, 3, 0, 99, 1'b0);
      wait_done(3000);

      // consumer stall for 20 cycles
      salt = 7; ready_mode = 2;
      start_scan(300, 310, 5, 1, 99, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock50Mhz);
         if (res_valid) begin ok = 1'b1; break; end
      end
      check("stall_valid_seen", ok, 1);
      repeat (20) @(negedge clock50Mhz);
      check("stall_valid_held", res_valid, 1);
      check("stall_one_load", n_load, 1);
      ready_mode = 0;
      wait_done(3000);

      // abort during the settle of the second step
      start_scan(10, 20, 5, 30, 1, 1'b0);
      for (int i = 0; i < 400 && n_load < 2; i++) @(negedge clock50Mhz);
      check("abort_second_load", n_load, 2);
      repeat (10) @(negedge clock50Mhz);
      abort = 1'b1;
      @(negedge clock50Mhz);
      abort = 1'b0;
      check("abort_done", done, 1);
      check("abort_busy", busy, 0);
      repeat (10) @(negedge clock50Mhz);
      check("abort_gates", n_gate, 1);
      check("abort_loads", n_load, 2);
      check("abort_records", exp_code.size(), 0);

      // reset while waiting for the counter
      cnt_delay_max = 40;
      start_scan(50, 60, 1, 2, 0, 1'b0);
      for (int i = 0; i < 400 && n_gate < 1; i++) @(negedge clock50Mhz);
      check("reset_test_gate", n_gate, 1);
      repeat (2) @(negedge clock50Mhz);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clock50Mhz);
      reset = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock50Mhz);
         if (done) ok = 1'b1;
      end
      check("reset_no_done", ok, 0);
      cnt_delay_max = 4;

      // randomized scans, first one with start and abort together
      ready_mode = 1;
      for (int k = 0; k < 6; k++) begin
         salt = $urandom;
         s  = $urandom_range(0, 4095);
         e  = (k == 3) ? s - $urandom_range(1, 20) : s + $urandom_range(0, 50);
         if (e > 4095) e = 4095;
         if (e < 0) e = 0;
         st = $urandom_range(1, 12);
         start_scan(s, e, st, $urandom_range(0, 5), 999, k == 0);
         wait_done(3000);
      end

`ifdef SCAN_TIMEOUT_EN
      cnt_enable = 1'b0;
      ready_mode = 0;
      start_scan(1, 2, 1, 0, 99, 1'b0);
      wait_done(3000);
      check("timeout_err_set", timeout_err, 1);
      cnt_enable = 1'b1;
      start_scan(5, 5, 1, 0, 99, 1'b0);
      check("timeout_err_cleared", timeout_err, 0);
      wait_done(3000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
